// File: rtl/output_port_scheduler.sv
// output_port_scheduler: round-robin scheduler that picks one virtual-channel flit per cycle for a shared output link
//   clk, rst            clock and asynchronous active-high reset
//   req_i               per-VC flit present
//   flit_i              per-VC flit, VC v in [v*FLIT_SIZE +: FLIT_SIZE], type in the top two bits
//   on_off_i            per-VC downstream credit (1 = can accept a flit)
//   vc_allocatable_i    per-VC downstream free for a new packet
//   grant_o             one-hot combinational grant (flit consumed this cycle)
//   data_o, valid_flit_o registered link flit and its valid
//   vc_busy_o           registered per-VC open-packet flag
// Optional macro OUTPUT_PORT_SCHEDULER_PKT_LOCK_EN: wormhole lock, the link stays on one VC from HEAD to TAIL.
module output_port_scheduler #(
    parameter int VC_NUM    = 2,
    parameter int FLIT_SIZE = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [VC_NUM-1:0]           req_i,
    input  logic [VC_NUM*FLIT_SIZE-1:0] flit_i,
    input  logic [VC_NUM-1:0]           on_off_i,
    input  logic [VC_NUM-1:0]           vc_allocatable_i,
    output logic [VC_NUM-1:0]           grant_o,
    output logic [FLIT_SIZE-1:0]        data_o,
    output logic                        valid_flit_o,
    output logic [VC_NUM-1:0]           vc_busy_o
);
    localparam int PW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    logic [VC_NUM-1:0]    elig_raw, elig, vc_busy_q, vc_busy_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d, gnt_idx;
    logic [FLIT_SIZE-1:0] gnt_flit, data_q, data_d;
    logic [1:0]           gnt_type;
    logic                 found, valid_q, valid_d, lock_q;
    // HEAD (00) and HEADTAIL (11) open a packet and need a free downstream VC;
    // BODY (01) and TAIL (10) may only continue an open one.
    always_comb begin
        for (int v = 0; v < VC_NUM; v++)
            elig_raw[v] = req_i[v] & on_off_i[v] &
                ((~^flit_i[v*FLIT_SIZE+FLIT_SIZE-2 +: 2]) ? (~vc_busy_q[v] & vc_allocatable_i[v]) : vc_busy_q[v]);
    end
`ifdef OUTPUT_PORT_SCHEDULER_PKT_LOCK_EN
    logic          lock_d;
    logic [PW-1:0] lock_vc_q, lock_vc_d;
    // While locked only the owning VC may win; anything else is a bubble.
    assign elig = lock_q ? (elig_raw & (VC_NUM'(1) << lock_vc_q)) : elig_raw;
    always_comb begin
        lock_d    = lock_q;
        lock_vc_d = lock_vc_q;
        if (found && gnt_type == 2'b00) begin
            lock_d    = 1'b1;
            lock_vc_d = gnt_idx;
        end else if (found && gnt_type == 2'b10) begin
            lock_d    = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_vc_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_vc_q <= lock_vc_d;
        end
    end
`else
    assign elig   = elig_raw;
    assign lock_q = 1'b0;
`endif
    // Search begins one past the last winner and wraps.
    always_comb begin
        int c;
        found   = 1'b0;
        gnt_idx = '0;
        for (int i = 1; i <= VC_NUM; i++) begin
            c = (int'(rr_ptr_q) + i) % VC_NUM;
            if (!found && elig[c]) begin
                found   = 1'b1;
                gnt_idx = PW'(c);
            end
        end
        gnt_flit = flit_i[gnt_idx*FLIT_SIZE +: FLIT_SIZE];
        gnt_type = gnt_flit[FLIT_SIZE-1 -: 2];
    end
    always_comb begin
        vc_busy_d = vc_busy_q;
        if (found && gnt_type == 2'b00) vc_busy_d[gnt_idx] = 1'b1;
        if (found && gnt_type == 2'b10) vc_busy_d[gnt_idx] = 1'b0;
        rr_ptr_d = (found && !lock_q) ? gnt_idx : rr_ptr_q;
        data_d   = found ? gnt_flit : data_q;
        valid_d  = found;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vc_busy_q <= '0;
            rr_ptr_q  <= PW'(VC_NUM - 1);
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            vc_busy_q <= vc_busy_d;
            rr_ptr_q  <= rr_ptr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end
    assign grant_o      = (rst || !found) ? '0 : (VC_NUM'(1) << gnt_idx);
    assign data_o       = data_q;
    assign valid_flit_o = valid_q;
    assign vc_busy_o    = vc_busy_q;
endmodule

// File: tb/tb_output_port_scheduler.sv
// tb_output_port_scheduler: directed and random checks of output_port_scheduler against a reference model
module tb_output_port_scheduler;
    localparam int VN = 2;
    localparam int FS = 16;
    logic clk = 1'b0;
    logic rst;
    logic [VN-1:0]    req_i, on_off_i, vc_allocatable_i, grant_o, vc_busy_o;
    logic [VN*FS-1:0] flit_i;
    logic [FS-1:0]    data_o;
    logic             valid_flit_o;
    int errors = 0;
    int checks = 0;
    int m_ptr, m_lock, m_g;
    bit m_busy [VN];
    logic [FS-1:0] m_data;
    bit m_valid;

    always #5 clk = ~clk;

    output_port_scheduler #(.VC_NUM(VN), .FLIT_SIZE(FS)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .flit_i(flit_i), .on_off_i(on_off_i),
        .vc_allocatable_i(vc_allocatable_i), .grant_o(grant_o), .data_o(data_o),
        .valid_flit_o(valid_flit_o), .vc_busy_o(vc_busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = VN - 1;
        m_lock = -1;
        m_data = '0;
        m_valid = 0;
        for (int v = 0; v < VN; v++) m_busy[v] = 0;
    endtask

    function automatic logic [VN-1:0] busy_vec();
        logic [VN-1:0] b;
        for (int v = 0; v < VN; v++) b[v] = m_busy[v];
        return b;
    endfunction

    // First VC after the last winner that may legally send its flit now.
    function automatic int pick();
        int c;
        logic [1:0] t;
        bit hd, ok;
        for (int k = 1; k <= VN; k++) begin
            c = (m_ptr + k) % VN;
            t = flit_i[c*FS+FS-2 +: 2];
            hd = (t == 2'b00) || (t == 2'b11);
            ok = req_i[c] && on_off_i[c] && (hd ? (!m_busy[c] && vc_allocatable_i[c]) : m_busy[c]);
            if (m_lock >= 0 && m_lock != c) ok = 0;
            if (ok) return c;
        end
        return -1;
    endfunction

    // Inputs are set just after a falling edge; grant is checked before the
    // rising edge, registered outputs just after it.
    task automatic cyc(input string tag);
        logic [1:0] t;
        logic [VN-1:0] eg;
        #1;
        m_g = pick();
        eg = (m_g < 0) ? '0 : VN'(1) << m_g;
        chk({tag, ".grant"}, 32'(grant_o), 32'(eg));
        @(posedge clk);
        if (m_g >= 0) begin
            t = flit_i[m_g*FS+FS-2 +: 2];
            m_data = flit_i[m_g*FS +: FS];
            m_valid = 1;
            if (m_lock < 0) m_ptr = m_g;
            if (t == 2'b00) m_busy[m_g] = 1;
            if (t == 2'b10) m_busy[m_g] = 0;
`ifdef OUTPUT_PORT_SCHEDULER_PKT_LOCK_EN
            if (t == 2'b00) m_lock = m_g;
            else if (t == 2'b10) m_lock = -1;
`endif
        end else begin
            m_valid = 0;
        end
        #1;
        chk({tag, ".data"}, 32'(data_o), 32'(m_data));
        chk({tag, ".valid"}, 32'(valid_flit_o), 32'(m_valid));
        chk({tag, ".busy"}, 32'(vc_busy_o), 32'(busy_vec()));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req_i = '0;
        flit_i = '0;
        on_off_i = '1;
        vc_allocatable_i = '1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst.grant", 32'(grant_o), 32'h0);
        chk("rst.data", 32'(data_o), 32'h0);
        chk("rst.valid", 32'(valid_flit_o), 32'h0);
        chk("rst.busy", 32'(vc_busy_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        // Two HEADTAILs: VC0 first, then VC1.
        req_i = 2'b11;
        flit_i = {16'hC0B1, 16'hC0A0};
        cyc("ht0");
        chk("ht0.vc0", 32'(data_o), 32'hC0A0);
        cyc("ht1");
        chk("ht1.vc1", 32'(data_o), 32'hC0B1);
        req_i = 2'b00;
        cyc("idle");
        // VC0 HEAD/BODY/TAIL packet.
        req_i = 2'b01;
        flit_i[15:0] = 16'h0001;
        cyc("pk.head");
        chk("pk.busy_set", 32'(vc_busy_o), 32'h1);
        flit_i[15:0] = 16'h4002;
        cyc("pk.body");
        flit_i[15:0] = 16'h8003;
        cyc("pk.tail");
        chk("pk.tail_data", 32'(data_o), 32'h8003);
        chk("pk.busy_clr", 32'(vc_busy_o), 32'h0);
        // BODY on a VC with no open packet is never granted.
        req_i = 2'b10;
        flit_i[31:16] = 16'h4005;
        cyc("orph0");
        cyc("orph1");
        chk("orph.valid", 32'(valid_flit_o), 32'h0);
        // HEAD waits for a free downstream VC.
        req_i = 2'b01;
        flit_i[15:0] = 16'h0010;
        vc_allocatable_i = 2'b10;
        repeat (3) cyc("alloc.wait");
        vc_allocatable_i = 2'b11;
        cyc("alloc.go");
        // Open a VC1 packet too, then stall VC0 for two cycles.
        req_i = 2'b10;
        flit_i[31:16] = 16'h0020;
        cyc("il.head1");
        req_i = 2'b11;
        flit_i = {16'h4021, 16'h4011};
        on_off_i = 2'b10;
        cyc("il.stall0");
        flit_i[31:16] = 16'h4022;
        cyc("il.stall1");
        on_off_i = 2'b11;
        flit_i = {16'h8023, 16'h8012};
        repeat (3) cyc("il.tails");
        // Reset in the middle of a VC0 packet.
        req_i = 2'b01;
        flit_i[15:0] = 16'h0030;
        cyc("mr.head");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("mr.grant", 32'(grant_o), 32'h0);
        chk("mr.busy", 32'(vc_busy_o), 32'h0);
        chk("mr.valid", 32'(valid_flit_o), 32'h0);
        chk("mr.data", 32'(data_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        flit_i[15:0] = 16'h4031;
        cyc("mr.body");
        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            req_i = VN'($urandom);
            on_off_i = VN'($urandom | $urandom);
            vc_allocatable_i = VN'($urandom | $urandom);
            flit_i = {16'($urandom), 16'($urandom)};
            cyc("rnd");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/output_port_scheduler.md
OUTPUT_PORT_SCHEDULER -- requirements
Module: output_port_scheduler

Interface
REQ-001 Parameter VC_NUM, default 2: number of virtual channels sharing the output link.
REQ-002 Parameter FLIT_SIZE, default 16: flit width; bits [FLIT_SIZE-1:FLIT_SIZE-2] are the flit type (00 HEAD, 01 BODY, 10 TAIL, 11 HEADTAIL).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_i  input  VC_NUM  bit v = VC v presents a flit.
REQ-006 flit_i  input  VC_NUM*FLIT_SIZE  flit of VC v in slice [v*FLIT_SIZE +: FLIT_SIZE].
REQ-007 on_off_i  input  VC_NUM  1 = downstream VC v accepts a flit this cycle.
REQ-008 vc_allocatable_i  input  VC_NUM  1 = downstream VC v free for a new packet.
REQ-009 grant_o  output  VC_NUM  one-hot or zero, combinational; bit v = flit of VC v consumed this cycle.
REQ-010 data_o  output  FLIT_SIZE  registered flit sent on the link.
REQ-011 valid_flit_o  output  1  registered; data_o is valid this cycle.
REQ-012 vc_busy_o  output  VC_NUM  registered; downstream VC v holds an open packet (head sent, tail pending).

Function
REQ-013 VC v SHALL be eligible iff req_i[v] & on_off_i[v] and either (type HEAD/HEADTAIL & !vc_busy_o[v] & vc_allocatable_i[v]) or (type BODY/TAIL & vc_busy_o[v]).
REQ-014 BODY/TAIL on a non-busy VC, or HEAD/HEADTAIL on a busy VC, SHALL NOT be eligible and SHALL never be granted.
REQ-015 Arbitration SHALL be round-robin: search starts at (rr_ptr+1) mod VC_NUM; the first eligible VC is granted.
REQ-016 rr_ptr SHALL update to the granted index only on a grant; with no grant rr_ptr holds.
REQ-017 At most one grant_o bit SHALL be set per cycle; grant_o SHALL be 0 when no VC is eligible.
REQ-018 On a grant, data_o SHALL take the granted flit and valid_flit_o SHALL be 1 on the next cycle (latency 1).
REQ-019 Without a grant, valid_flit_o SHALL be 0 next cycle and data_o SHALL hold its previous value.
REQ-020 A HEAD grant SHALL set vc_busy_o[v] next cycle; a TAIL grant SHALL clear it; HEADTAIL and BODY SHALL leave it unchanged.
REQ-021 rr_ptr wraps from VC_NUM-1 to 0; throughput SHALL be one flit per cycle when any VC is eligible.
REQ-022 on_off_i dropping mid-packet SHALL only stall that VC; other VCs remain eligible (unless REQ-027 applies).

Reset
REQ-023 rst assertion SHALL asynchronously force data_o=0, valid_flit_o=0, vc_busy_o=0, rr_ptr=VC_NUM-1 (so VC 0 is searched first).
REQ-024 grant_o SHALL be 0 while rst is asserted.
REQ-025 Reset mid-packet SHALL discard all open-packet state; after release only HEAD/HEADTAIL flits are eligible.

Configuration
REQ-026 Macro OUTPUT_PORT_SCHEDULER_PKT_LOCK_EN selects wormhole link locking.
REQ-027 Defined: after a HEAD grant on VC v, only VC v is eligible until its TAIL is granted; cycles with VC v ineligible SHALL produce no grant (bubble); rr_ptr holds during lock.
REQ-028 Undefined: flit-level interleaving per REQ-013..REQ-022; no lock state exists.

Verification (VC_NUM=2, FLIT_SIZE=16)
REQ-029 Reset then req_i=11, both HEADTAIL, on_off_i=11, vc_allocatable_i=11 -> grant_o 01 then 10; valid_flit_o=1 in cycles 2 and 3 with matching data_o.
REQ-030 VC0 HEAD 0x0001, BODY 0x4002, TAIL 0x8003, all inputs enabled -> vc_busy_o[0]=1 after HEAD, 0 after TAIL; data_o sequence 0x0001, 0x4002, 0x8003.
REQ-031 VC1 BODY with vc_busy_o=00 -> grant_o stays 00, valid_flit_o stays 0.
REQ-032 VC0 HEAD with vc_allocatable_i[0]=0 for 3 cycles, then 1 -> no grant for 3 cycles, grant_o=01 on the 4th.
REQ-033 Interleave (macro off): VC0 and VC1 packets pending, on_off_i[0]=0 for 2 cycles -> VC1 flits granted back-to-back in those cycles; with the macro on and VC0 locked -> 2 bubble cycles, no VC1 grant.
REQ-034 Assert rst after VC0 HEAD is sent -> vc_busy_o=00 and valid_flit_o=0 immediately; a subsequent VC0 BODY is not granted.
